// File: rtl/data_ram_mmio.sv
// Data-side RAM for the five-stage core with an optional memory-mapped TX FIFO window.
// Define DMEM_MMIO_EN to build the MMIO window (TXDATA/STATUS/DROPS) and TX FIFO; otherwise all addresses map to RAM.
module data_ram_mmio #(
   parameter int          ADDR_BITS  = 12,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [31:0] mem_addr_i,
   input  logic [3:0]  mem_mask_i,
   input  logic [31:0] mem_wdata_i,
   output logic [31:0] mem_rdata_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i
);

   localparam int WORDS = 1 << ADDR_BITS;

   logic [31:0]          ram [WORDS];
   logic [ADDR_BITS-1:0] word_idx;
   logic                 ram_hit;
   logic [31:0]          mmio_rdata;

   assign word_idx = mem_addr_i[ADDR_BITS+1:2];

`ifdef DMEM_MMIO_EN
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic             mmio_hit;
   logic [5:0]       reg_sel;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic [7:0]       count_ext;
   logic [7:0]       drop_cnt;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push_req;
   logic             push;
   logic             pop;
   logic             drops_clear;
   logic             unused_ok;

   assign mmio_hit    = (mem_addr_i[31:8] == MMIO_BASE[31:8]);
   assign ram_hit     = !mmio_hit;
   assign reg_sel     = mem_addr_i[7:2];
   assign fifo_empty  = (count == '0);
   assign fifo_full   = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign pop         = !fifo_empty && tx_ready_i;
   assign push_req    = mem_write_i && mmio_hit && (reg_sel == 6'd0) && mem_mask_i[0];
   // A full FIFO still accepts a byte when the head leaves on the same edge.
   assign push        = push_req && (!fifo_full || pop);
   assign drops_clear = mem_write_i && mmio_hit && (reg_sel == 6'd2);
   assign count_ext   = 8'(count);
   assign unused_ok   = &{1'b0, mem_addr_i[1:0]};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         drop_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + (PTR_W+1)'(1);
         else if (pop && !push)
            count <= count - (PTR_W+1)'(1);
         if (drops_clear)
            drop_cnt <= '0;
         else if (push_req && !push && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (push)
         fifo_mem[wr_ptr] <= mem_wdata_i[7:0];
   end

   // Head byte is forced to zero while empty so reset and drained states read clean.
   assign tx_valid_o = !fifo_empty;
   assign tx_data_o  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

   always_comb begin
      mmio_rdata = '0;
      case (reg_sel)
         6'd1:    mmio_rdata = {24'b0, count_ext[3:0], 2'b00, fifo_full, fifo_empty};
         6'd2:    mmio_rdata = {24'b0, drop_cnt};
         default: mmio_rdata = '0;
      endcase
   end
`else
   logic unused_ok;

   assign ram_hit    = 1'b1;
   assign mmio_rdata = '0;
   assign tx_valid_o = 1'b0;
   assign tx_data_o  = 8'h00;
   assign unused_ok  = &{1'b0, mem_addr_i[1:0], mem_addr_i[31:ADDR_BITS+2], tx_ready_i,
                         MMIO_BASE[0], FIFO_DEPTH[0]};
`endif

   always_ff @(posedge CLK) begin
      if (mem_write_i && ram_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_mask_i[b])
               ram[word_idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
         end
      end
   end

   // Loads are combinational so the MEM stage gets its data in the same cycle.
   assign mem_rdata_o = !mem_read_i ? 32'h0 : (ram_hit ? ram[word_idx] : mmio_rdata);

endmodule

// File: tb/tb_data_ram_mmio.sv
// Scoreboard bench for data_ram_mmio: a behavioural model predicts loads and TX bytes, monitors compare.
module tb_data_ram_mmio;

   localparam int          ADDR_BITS  = 12;
   localparam int          FIFO_DEPTH = 4;
   localparam logic [31:0] MMIO_BASE  = 32'hFFFF_FF00;
`ifdef DMEM_MMIO_EN
   localparam bit MMIO_EN = 1'b1;
`else
   localparam bit MMIO_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        mem_read_i = 1'b0;
   logic        mem_write_i = 1'b0;
   logic [31:0] mem_addr_i = '0;
   logic [3:0]  mem_mask_i = '0;
   logic [31:0] mem_wdata_i = '0;
   logic [31:0] mem_rdata_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] model_mem [int];
   int          model_cnt = 0;
   int          model_drops = 0;
   logic [31:0] rd_exp_q [$];
   logic [7:0]  tx_exp_q [$];

   data_ram_mmio #(
      .ADDR_BITS (ADDR_BITS),
      .FIFO_DEPTH(FIFO_DEPTH),
      .MMIO_BASE (MMIO_BASE)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .mem_read_i (mem_read_i),
      .mem_write_i(mem_write_i),
      .mem_addr_i (mem_addr_i),
      .mem_mask_i (mem_mask_i),
      .mem_wdata_i(mem_wdata_i),
      .mem_rdata_o(mem_rdata_o),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready_i)
   );

   always #5 CLK = ~CLK;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic bit is_mmio(input logic [31:0] addr);
      return MMIO_EN && (addr[31:8] == MMIO_BASE[31:8]);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr);
      int key;
      if (is_mmio(addr)) begin
         case (addr[7:2])
            6'd1: return {24'b0, 4'(model_cnt), 2'b00, 1'(model_cnt == FIFO_DEPTH), 1'(model_cnt == 0)};
            6'd2: return 32'(model_drops);
            default: return 32'h0;
         endcase
      end
      key = int'(addr[ADDR_BITS+1:2]);
      if (model_mem.exists(key))
         return model_mem[key];
      return 32'hxxxx_xxxx;
   endfunction

   // One clock cycle: drive inputs, predict the response, then advance the model past the coming edge.
   task automatic apply_stimulus(input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [3:0] mask, input logic [31:0] wdata, input bit ready);
      bit          hit;
      bit          pop;
      bit          push_req;
      int          key;
      logic [31:0] word;
      @(posedge CLK);
      #1;
      mem_read_i  = rd;
      mem_write_i = wr;
      mem_addr_i  = addr;
      mem_mask_i  = mask;
      mem_wdata_i = wdata;
      tx_ready_i  = ready;
      check_output("tx_valid", 32'(tx_valid_o), 32'(model_cnt > 0));
      if (rd)
         rd_exp_q.push_back(model_read(addr));
      #1;
      if (!rd)
         check_output("rdata_idle", mem_rdata_o, 32'h0);
      hit      = is_mmio(addr);
      pop      = (model_cnt > 0) && ready;
      push_req = wr && hit && (addr[7:2] == 6'd0) && mask[0];
      if (push_req) begin
         if (model_cnt < FIFO_DEPTH || pop) begin
            tx_exp_q.push_back(wdata[7:0]);
            model_cnt++;
         end else if (model_drops < 255) begin
            model_drops++;
         end
      end
      if (pop)
         model_cnt--;
      if (wr && hit && addr[7:2] == 6'd2)
         model_drops = 0;
      if (wr && !hit) begin
         key  = int'(addr[ADDR_BITS+1:2]);
         word = model_mem.exists(key) ? model_mem[key] : 32'hxxxx_xxxx;
         for (int b = 0; b < 4; b++)
            if (mask[b])
               word[8*b +: 8] = wdata[8*b +: 8];
         model_mem[key] = word;
      end
   endtask

   task automatic store(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] wdata, input bit ready);
      apply_stimulus(1'b0, 1'b1, addr, mask, wdata, ready);
   endtask

   task automatic load(input logic [31:0] addr, input bit ready);
      apply_stimulus(1'b1, 1'b0, addr, 4'h0, 32'h0, ready);
   endtask

   task automatic idle(input bit ready);
      apply_stimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, ready);
   endtask

   task automatic drain();
      for (int i = 0; i < 3 * FIFO_DEPTH && model_cnt > 0; i++)
         idle(1'b1);
      idle(1'b0);
   endtask

   task automatic reset_pulse();
      @(posedge CLK);
      #1;
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      tx_ready_i  = 1'b0;
      RST = 1'b1;
      #1;
      check_output("tx_valid_rst", 32'(tx_valid_o), 32'h0);
      check_output("tx_data_rst", 32'(tx_data_o), 32'h0);
      RST = 1'b0;
      model_cnt   = 0;
      model_drops = 0;
      tx_exp_q.delete();
   endtask

   // Monitor: pops expected load data and TX bytes whenever the DUT presents them.
   always @(negedge CLK) begin
      logic [31:0] exp_rd;
      logic [7:0]  exp_tx;
      if (!RST) begin
         if (mem_read_i) begin
            if (rd_exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL rd_scoreboard: got %h with no expectation queued", mem_rdata_o);
            end else begin
               exp_rd = rd_exp_q.pop_front();
               if (!$isunknown(exp_rd))
                  check_output("rdata", mem_rdata_o, exp_rd);
            end
         end
         if (tx_valid_o && tx_ready_i) begin
            if (tx_exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL tx_scoreboard: got byte %h with none expected", tx_data_o);
            end else begin
               exp_tx = tx_exp_q.pop_front();
               check_output("tx_data", 32'(tx_data_o), 32'(exp_tx));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] addr;
      #3;
      check_output("reset_tx_valid", 32'(tx_valid_o), 32'h0);
      check_output("reset_tx_data", 32'(tx_data_o), 32'h0);
      check_output("reset_rdata", mem_rdata_o, 32'h0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;

      load(MMIO_BASE + 32'h4, 1'b0);
      store(32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b0);
      store(32'h10, 4'b0001, 32'h0000_00AA, 1'b0);
      load(32'h10, 1'b0);
      idle(1'b0);

      for (int i = 0; i < 4; i++)
         store(MMIO_BASE, 4'b0001, 32'h41 + 32'(i), 1'b0);
      load(MMIO_BASE + 32'h4, 1'b0);
      store(MMIO_BASE, 4'b0001, 32'h45, 1'b0);
      load(MMIO_BASE + 32'h8, 1'b0);
      for (int i = 0; i < 5; i++)
         idle(1'b1);
      load(MMIO_BASE + 32'h4, 1'b0);

      for (int i = 0; i < 4; i++)
         store(MMIO_BASE, 4'b0001, 32'h61 + 32'(i), 1'b0);
      store(MMIO_BASE, 4'b0001, 32'h55, 1'b1);
      load(MMIO_BASE + 32'h4, 1'b0);
      load(MMIO_BASE + 32'h8, 1'b0);
      drain();

      for (int i = 0; i < 10; i++) begin
         store(MMIO_BASE, 4'b0001, 32'(i), 1'b0);
         idle(1'b1);
      end
      load(MMIO_BASE + 32'h4, 1'b0);

      for (int i = 0; i < FIFO_DEPTH + 260; i++)
         store(MMIO_BASE, 4'b0001, 32'h80 + 32'(i), 1'b0);
      load(MMIO_BASE + 32'h8, 1'b0);
      drain();

      store(32'h20, 4'b1111, 32'h1234_5678, 1'b0);
      store(MMIO_BASE + 32'h8, 4'b1111, 32'h0, 1'b0);
      for (int i = 0; i < FIFO_DEPTH + 2; i++)
         store(MMIO_BASE, 4'b0001, 32'hC0 + 32'(i), 1'b0);
      idle(1'b1);
      idle(1'b0);
      reset_pulse();
      load(MMIO_BASE + 32'h4, 1'b0);
      load(MMIO_BASE + 32'h8, 1'b0);
      load(32'h20, 1'b0);

      store(MMIO_BASE, 4'b1111, 32'h0000_0077, 1'b0);
      load(MMIO_BASE, 1'b0);
      drain();

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) < 6)
            addr = 32'($urandom_range(0, 15) * 4) | (32'($urandom_range(0, 3)) << (ADDR_BITS + 2));
         else
            addr = MMIO_BASE + 32'($urandom_range(0, 3) * 4);
         apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr,
                        4'($urandom), $urandom, 1'($urandom_range(0, 1)));
      end

      drain();
      idle(1'b0);
      check_output("tx_queue_empty", 32'(tx_exp_q.size()), 32'h0);
      check_output("rd_queue_empty", 32'(rd_exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_ram_mmio.md
# data_ram_mmio

Data-side memory responder for the five-stage core: serves the core's load/store port (read/write strobes, word address, byte mask, write data) and returns read data in the same cycle, as the MEM stage requires. A small memory-mapped transmit region decodes above the RAM: byte stores there push into a TX FIFO that drains over a valid/ready handshake toward a downstream serial or debug sink.

## Interface
- ADDR_BITS, 12, word-index width; RAM holds 2^ADDR_BITS 32-bit words.
- FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..16).
- MMIO_BASE, 32'hFFFF_FF00, base of the 256-byte MMIO window.

- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- mem_read_i  input  1  load request from the core's MEM stage.
- mem_write_i  input  1  store request.
- mem_addr_i  input  32  byte address; bits [1:0] ignored.
- mem_mask_i  input  4  byte enables; bit i enables bits [8i+7:8i], little-endian.
- mem_wdata_i  input  32  store data, already lane-aligned by the core.
- mem_rdata_o  output  32  load data, combinational.
- tx_data_o  output  8  FIFO head byte.
- tx_valid_o  output  1  FIFO non-empty.
- tx_ready_i  input  1  sink accepts head byte this edge.

## Operation
- Decode: MMIO hit when mem_addr_i[31:8] == MMIO_BASE[31:8]; otherwise RAM at word index mem_addr_i[ADDR_BITS+1:2]. Higher bits are ignored, so the RAM aliases.
- RAM write: when mem_write_i is high on a RAM hit, each byte lane with mask=1 is written at the edge; mask=0 lanes are unchanged. RAM contents are not reset.
- RAM read: when mem_read_i is high on a RAM hit, mem_rdata_o is the full word, asynchronous. The core extracts bytes and halves. mem_rdata_o = 0 whenever mem_read_i is low.
- MMIO registers (offset = mem_addr_i[7:0]):
  - 0x00 TXDATA: a write with mem_mask_i[0]=1 pushes mem_wdata_i[7:0]. Reads return 0.
  - 0x04 STATUS: read returns {24'b0, count[3:0], 2'b0, full, empty}. Writes are ignored.
  - 0x08 DROPS: read returns {24'b0, drop_cnt}. Any write clears it to 0.
  - Other offsets read 0; writes are ignored.
- FIFO behaviour:
  - Circular buffer with wrap-around read/write pointers and a count.
  - Push when count < FIFO_DEPTH, or when the FIFO is full and a pop happens on the same edge.
  - Otherwise the push is dropped and drop_cnt increments, saturating at 255.
  - Pop on an edge where tx_valid_o && tx_ready_i.
  - Simultaneous push and pop leaves count unchanged.
- Simultaneous mem_read_i and mem_write_i to the same word: read returns pre-write contents; the write lands at the edge.

## Timing
- Reset values:
  - tx_valid_o = 0, tx_data_o = 0.
  - count, pointers and drop_cnt = 0.
  - mem_rdata_o = 0 unless mem_read_i is asserted. STATUS reads 0x01 after reset.
- Load latency is 0 cycles: data is valid in the same cycle as mem_read_i.
- Store latency is 1 edge: a load of the same word in the next cycle sees the new data.
- Push to tx_valid_o: a push at edge N makes tx_valid_o high and tx_data_o equal to the pushed byte after edge N (first-word fall-through from registered state).
- tx_data_o is stable while tx_valid_o && !tx_ready_i.
- STATUS and DROPS reads reflect registered state, i.e. they exclude any push or pop at the coming edge.
- RST asserted mid-stream: the FIFO empties immediately and asynchronously, tx_valid_o drops the same cycle, and queued bytes are lost.

## Configuration
- DMEM_MMIO_EN defined: the MMIO window and TX FIFO are present as described.
- DMEM_MMIO_EN undefined:
  - No MMIO decode; every address maps to RAM, including MMIO_BASE.
  - tx_valid_o and tx_data_o are tied to 0, and tx_ready_i is ignored.
  - No FIFO or counter logic is synthesised.

## Test plan
- Byte-masked store: write 0xDEADBEEF to 0x10 with mask 4'b1111, then 0x000000AA with mask 4'b0001. Read 0x10 -> 0xDEADBEAA. Read with mem_read_i=0 -> 0.
- FIFO fill and drain: tx_ready_i=0; push 0x41,0x42,0x43,0x44 -> STATUS 0x42. A fifth push is dropped -> DROPS reads 1. Raise tx_ready_i -> bytes emerge in order 0x41..0x44 on consecutive edges, then STATUS 0x01.
- Full with simultaneous push/pop: FIFO full, tx_ready_i=1, push 0x55 on the same edge -> count stays 4, DROPS unchanged, 0x55 emerges last.
- Pointer wrap: push and pop 10 bytes 0x00..0x09 one at a time -> received sequence identical, STATUS 0x01 at end.
- Reset mid-operation: 3 bytes queued, drop_cnt=2; pulse RST between edges -> tx_valid_o low immediately, STATUS 0x01, DROPS 0. A previously written RAM word is retained.
- Macro off: store 0x77 to MMIO_BASE, then read MMIO_BASE -> 0x00000077; tx_valid_o stays 0.
